// File: rtl/sd_bus_scheduler.sv
// Serialises block read/write commands from two requesters onto one SD SPI bus,
// with round-robin arbitration, per-operation timeout and an idle gap between operations.
module sd_bus_scheduler #(
    parameter int unsigned TIMEOUT = 5000000,
    parameter int unsigned GAP     = 8
) (
    input  logic        SD_clk,
    input  logic        rst_n,
    input  logic        init_o,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_wr,
    input  logic [31:0] req_sec0,
    input  logic [31:0] req_sec1,
    output logic [1:0]  req_ready,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    output logic        write_req,
    output logic        read_req,
    output logic [31:0] write_sec,
    output logic [31:0] read_sec,
    input  logic        write_o,
    input  logic        read_o,
    input  logic        SD_cs_i,
    input  logic        SD_datain_i,
    input  logic        SD_cs_w,
    input  logic        SD_datain_w,
    input  logic        SD_cs_r,
    input  logic        SD_datain_r,
    output logic        SD_cs,
    output logic        SD_datain
);

    localparam logic [2:0] StInit  = 3'd0;
    localparam logic [2:0] StIdle  = 3'd1;
    localparam logic [2:0] StWrite = 3'd2;
    localparam logic [2:0] StRead  = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;

    localparam logic [22:0] TimeoutLast = 23'(TIMEOUT - 1);
    localparam logic [22:0] GapLast     = 23'(GAP - 1);

    logic [2:0]  state_q;
    logic [22:0] cnt_q;
    logic        last_q;
    logic        owner_q;

    logic        grant_valid;
    logic        grant_id;
    logic [31:0] grant_sec;
    logic        complete;
    logic        expired;
    logic [1:0]  owner_onehot;

    // Requester after the last-granted one has priority on a tie.
    assign grant_valid  = (state_q == StIdle) && (req_valid != 2'b00);
    assign grant_id     = (req_valid == 2'b11) ? ~last_q : ~req_valid[0];
    assign grant_sec    = grant_id ? req_sec1 : req_sec0;
    assign req_ready    = grant_valid ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

    // Completion wins over a coincident timeout.
    assign complete     = ((state_q == StWrite) && write_o) || ((state_q == StRead) && read_o);
    assign expired      = ((state_q == StWrite) || (state_q == StRead)) &&
                          (cnt_q == TimeoutLast) && !complete;
    assign owner_onehot = owner_q ? 2'b10 : 2'b01;
    assign req_done     = complete ? owner_onehot : 2'b00;
    assign req_err      = expired ? owner_onehot : 2'b00;

    always_ff @(posedge SD_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            write_req <= 1'b0;
            read_req  <= 1'b0;
            write_sec <= '0;
            read_sec  <= '0;
        end else begin
            write_req <= 1'b0;
            read_req  <= 1'b0;
            case (state_q)
                StInit: begin
                    if (init_o) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (grant_valid) begin
                        owner_q <= grant_id;
                        last_q  <= grant_id;
                        cnt_q   <= '0;
                        if (req_wr[grant_id]) begin
                            state_q   <= StWrite;
                            write_req <= 1'b1;
                            write_sec <= grant_sec;
                        end else begin
                            state_q  <= StRead;
                            read_req <= 1'b1;
                            read_sec <= grant_sec;
                        end
                    end
                end
                StWrite, StRead: begin
                    if (complete || expired) begin
                        state_q <= StGap;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 23'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 23'd1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    always_comb begin
        SD_cs     = 1'b1;
        SD_datain = 1'b1;
        case (state_q)
            StInit: begin
                SD_cs     = SD_cs_i;
                SD_datain = SD_datain_i;
            end
            StWrite: begin
                SD_cs     = SD_cs_w;
                SD_datain = SD_datain_w;
            end
            StRead: begin
                SD_cs     = SD_cs_r;
                SD_datain = SD_datain_r;
            end
            default: begin
                SD_cs     = 1'b1;
                SD_datain = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sd_bus_scheduler.sv
// Bench for sd_bus_scheduler: timestamp-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sd_bus_scheduler;

    localparam int TO  = 50;
    localparam int GP  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_o;
    logic [1:0]  req_valid, req_wr;
    logic [31:0] req_sec0, req_sec1;
    logic [1:0]  req_ready, req_done, req_err;
    logic        write_req, read_req;
    logic [31:0] write_sec, read_sec;
    logic        write_o, read_o;
    logic        cs_i, din_i, cs_w, din_w, cs_r, din_r;
    logic        SD_cs, SD_datain;

    sd_bus_scheduler #(.TIMEOUT(TO), .GAP(GP)) dut (
        .SD_clk(clk), .rst_n(rst_n), .init_o(init_o),
        .req_valid(req_valid), .req_wr(req_wr), .req_sec0(req_sec0), .req_sec1(req_sec1),
        .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
        .write_req(write_req), .read_req(read_req), .write_sec(write_sec), .read_sec(read_sec),
        .write_o(write_o), .read_o(read_o),
        .SD_cs_i(cs_i), .SD_datain_i(din_i), .SD_cs_w(cs_w), .SD_datain_w(din_w),
        .SD_cs_r(cs_r), .SD_datain_r(din_r),
        .SD_cs(SD_cs), .SD_datain(SD_datain)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=init 1=idle 2=write 3=read 4=gap; time in mode from timestamps.
    int          now = 0;
    int          m_mode = 0;
    int          m_since = 0;
    bit          m_last = 1'b1;
    bit          m_own = 1'b0;
    logic [31:0] m_wsec = '0;
    logic [31:0] m_rsec = '0;

    logic [1:0]  got_ready, got_done, got_err;
    logic        got_wreq, got_rreq, got_cs;
    logic [31:0] got_wsec, got_rsec;

    function automatic bit winner(input logic [1:0] v, input bit last);
        bit pref;
        pref = !last;
        return v[pref] ? pref : !pref;
    endfunction

    function automatic logic [1:0] onehot(input bit n);
        return n ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [73:0] model_outs();
        logic [1:0]  rdy, dn, er;
        logic        wq, rq, cs, din;
        int          el;
        bit          fin;
        if (!rst_n) return {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, cs_i, din_i};
        el  = now - m_since;
        rdy = (m_mode == 1 && req_valid != 0) ? onehot(winner(req_valid, m_last)) : 2'b00;
        fin = (m_mode == 2 && write_o) || (m_mode == 3 && read_o);
        dn  = fin ? onehot(m_own) : 2'b00;
        er  = ((m_mode == 2 || m_mode == 3) && !fin && el == TO - 1) ? onehot(m_own) : 2'b00;
        wq  = (m_mode == 2 && el == 0);
        rq  = (m_mode == 3 && el == 0);
        case (m_mode)
            0:       begin cs = cs_i; din = din_i; end
            2:       begin cs = cs_w; din = din_w; end
            3:       begin cs = cs_r; din = din_r; end
            default: begin cs = 1'b1; din = 1'b1; end
        endcase
        return {rdy, dn, er, wq, rq, m_wsec, m_rsec, cs, din};
    endfunction

    task automatic enter(input int m);
        m_mode  = m;
        m_since = now + 1;
    endtask

    task automatic model_step();
        int el;
        bit w;
        el = now - m_since;
        if (!rst_n) begin
            m_mode = 0; m_last = 1'b1; m_own = 1'b0; m_wsec = '0; m_rsec = '0;
        end else begin
            case (m_mode)
                0: if (init_o) enter(1);
                1: if (req_valid != 0) begin
                    w = winner(req_valid, m_last);
                    m_own = w;
                    m_last = w;
                    if (req_wr[w]) begin
                        m_wsec = w ? req_sec1 : req_sec0;
                        enter(2);
                    end else begin
                        m_rsec = w ? req_sec1 : req_sec0;
                        enter(3);
                    end
                end
                2, 3: if ((m_mode == 2 && write_o) || (m_mode == 3 && read_o) || el == TO - 1)
                    enter(4);
                default: if (el == GP - 1) enter(1);
            endcase
        end
        now++;
    endtask

    // One clock cycle: inputs already driven; compare at negedge, advance model, move past edge.
    task automatic cyc();
        logic [73:0] exp_v, got_v;
        @(negedge clk);
        exp_v = model_outs();
        got_v = {req_ready, req_done, req_err, write_req, read_req, write_sec, read_sec,
                 SD_cs, SD_datain};
        got_ready = req_ready; got_done = req_done; got_err = req_err;
        got_wreq = write_req; got_rreq = read_req; got_wsec = write_sec; got_rsec = read_sec;
        got_cs = SD_cs;
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL outs t=%0d got=%h exp=%h", now, got_v, exp_v);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic gap_cycles();
        for (int i = 0; i < GP; i++) cyc();
    endtask

    int n;

    initial begin
        rst_n = 1'b0; init_o = 1'b0; req_valid = '0; req_wr = '0;
        req_sec0 = '0; req_sec1 = '0; write_o = 1'b0; read_o = 1'b0;
        cs_i = 1'b0; din_i = 1'b1; cs_w = 1'b0; din_w = 1'b0; cs_r = 1'b0; din_r = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc();
        check("rst_ready", {30'h0, got_ready}, 32'h0);
        check("rst_wsec", got_wsec, 32'h0);
        check("rst_cs_follows_i", {31'h0, got_cs}, 32'h0);

        rst_n = 1'b1;
        repeat (97) cyc();
        init_o = 1'b1;
        cyc();
        cyc();
        check("idle_cs", {31'h0, got_cs}, 32'h1);
        check("idle_no_ready", {30'h0, got_ready}, 32'h0);

        // Both valid: req0 write 0x10, req1 read 0x20.
        req_valid = 2'b11; req_wr = 2'b01; req_sec0 = 32'h10; req_sec1 = 32'h20;
        cyc();
        check("tie_grant0", {30'h0, got_ready}, 32'h1);
        req_valid = 2'b10;
        cyc();
        check("write_req", {31'h0, got_wreq}, 32'h1);
        check("write_sec", got_wsec, 32'h10);
        repeat (3) cyc();
        write_o = 1'b1;
        cyc();
        check("write_done", {30'h0, got_done}, 32'h1);
        write_o = 1'b0;
        for (int i = 0; i < GP; i++) begin
            cyc();
            check("gap_wait", {30'h0, got_ready}, 32'h0);
        end
        cyc();
        check("grant1_after_gap", {30'h0, got_ready}, 32'h2);
        req_valid = 2'b00;
        cyc();
        check("read_req", {31'h0, got_rreq}, 32'h1);
        check("read_sec", got_rsec, 32'h20);

        // Timeout: read_o never comes; err expected on READ cycle TO.
        n = 1;
        for (int k = 2; k <= 200; k++) begin
            cyc();
            n = k;
            if (got_err != 2'b00) break;
        end
        check("timeout_cycle", n, TO);
        check("timeout_err", {30'h0, got_err}, 32'h2);
        check("timeout_no_done", {30'h0, got_done}, 32'h0);
        gap_cycles();

        // Completion coinciding with the last timeout cycle.
        req_valid = 2'b01; req_wr = 2'b00; req_sec0 = 32'h30;
        cyc();
        check("grant0_read", {30'h0, got_ready}, 32'h1);
        req_valid = 2'b00;
        repeat (TO - 1) cyc();
        read_o = 1'b1;
        cyc();
        check("coinc_done", {30'h0, got_done}, 32'h1);
        check("coinc_no_err", {30'h0, got_err}, 32'h0);
        read_o = 1'b0;
        gap_cycles();

        // req1 alone, then a tie goes back to req0.
        req_valid = 2'b10; req_wr = 2'b11; req_sec1 = 32'h40;
        cyc();
        check("alone_grant1", {30'h0, got_ready}, 32'h2);
        req_valid = 2'b00;
        repeat (2) cyc();
        write_o = 1'b1;
        cyc();
        write_o = 1'b0;
        gap_cycles();
        req_valid = 2'b11; req_sec0 = 32'h44;
        cyc();
        check("rr_grant0", {30'h0, got_ready}, 32'h1);
        req_valid = 2'b00;
        repeat (2) cyc();

        // Reset in the middle of a write: no done pulse, state cleared.
        rst_n = 1'b0; write_o = 1'b1;
        cyc();
        check("rst_mid_no_done", {30'h0, got_done}, 32'h0);
        check("rst_mid_wsec", got_wsec, 32'h0);
        rst_n = 1'b1; write_o = 1'b0;
        cyc();
        req_valid = 2'b01; req_wr = 2'b01; req_sec0 = 32'h55;
        cyc();
        check("post_rst_grant", {30'h0, got_ready}, 32'h1);
        req_valid = 2'b00;
        cyc();
        check("post_rst_wsec", got_wsec, 32'h55);
        write_o = 1'b1;
        cyc();
        check("post_rst_done", {30'h0, got_done}, 32'h1);
        write_o = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            init_o    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) req_valid = 2'($urandom_range(0, 3));
            req_wr    = 2'($urandom_range(0, 3));
            req_sec0  = $urandom;
            req_sec1  = $urandom;
            write_o   = ($urandom_range(0, 39) == 0);
            read_o    = ($urandom_range(0, 39) == 0);
            {cs_i, din_i, cs_w, din_w, cs_r, din_r} = 6'($urandom_range(0, 63));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
